// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - sequencer feeding aes_key_gen one round at a time and streaming round keys 0..NUM_ROUNDS
// Optional round-key store with replay: define KEY_SCHED_CACHE_EN.
module aes_key_sched_ctrl #(
  parameter int         NUM_ROUNDS = 10,
  parameter logic [7:0] RCON_INIT  = 8'h01
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  output logic         start_ready,
  input  logic [127:0] key_i,
  input  logic         abort,
  output logic         kg_en,
  output logic         kg_gen_key,
  output logic         kg_next_rnd,
  output logic [7:0]   kg_rcon,
  output logic [127:0] kg_key,
  input  logic [127:0] kg_key_o,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
`ifdef KEY_SCHED_CACHE_EN
  input  logic         replay,
  output logic         cache_valid,
`endif
  output logic         done
);

  typedef enum logic [1:0] {IDLE, OUT, STEP} state_t;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  state_t         state, state_nx;
  logic [3:0]     idx;
  logic [7:0]     rcon;
  logic [127:0]   key_q;
  logic           done_q;
  logic           hs;
  logic           last;
  logic           use_replay;
  logic           rep;
  logic [127:0]   stored_key;

  assign hs   = (state == OUT) && rk_ready;
  assign last = (idx == LAST);

  always_comb begin
    state_nx    = state;
    start_ready = 1'b0;
    rk_valid    = 1'b0;
    kg_en       = 1'b0;
    kg_gen_key  = 1'b0;
    kg_next_rnd = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start) state_nx = OUT;
      end
      OUT: begin
        rk_valid = 1'b1;
        if (abort)         state_nx = IDLE;
        else if (rk_ready) state_nx = last ? IDLE : (rep ? OUT : STEP);
      end
      STEP: begin
        kg_en       = 1'b1;
        kg_gen_key  = 1'b1;
        kg_next_rnd = (idx != 4'd0);
        state_nx    = abort ? IDLE : OUT;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state  <= IDLE;
      idx    <= 4'd0;
      rcon   <= RCON_INIT;
      key_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= hs && last && !abort;
      if (state == IDLE) begin
        if (start) begin
          idx  <= 4'd0;
          rcon <= RCON_INIT;
          if (!use_replay) key_q <= key_i;
        end
      end else if (abort || (hs && last)) begin
        idx  <= 4'd0;
        rcon <= RCON_INIT;
      end else if (state == STEP) begin
        idx  <= idx + 4'd1;
        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);
      end else if (hs && rep) begin
        idx  <= idx + 4'd1;
      end
    end
  end

`ifdef KEY_SCHED_CACHE_EN
  logic           rep_q;
  logic           cache_q;
  logic [127:0]   store [0:NUM_ROUNDS];

  assign use_replay  = replay && cache_q;
  assign rep         = rep_q;
  assign cache_valid = cache_q;
  assign stored_key  = store[idx];

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      rep_q   <= 1'b0;
      cache_q <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        rep_q <= use_replay;
        if (!use_replay) cache_q <= 1'b0;
      end
    end else if (abort) begin
      rep_q   <= 1'b0;
      cache_q <= 1'b0;
    end else if (hs && last) begin
      rep_q   <= 1'b0;
      cache_q <= 1'b1;
    end
  end

  // Replayed keys rewrite their own slot with identical data, so no replay gating is needed.
  always_ff @(posedge clk) begin
    if (hs) store[idx] <= rk_data;
  end
`else
  assign use_replay = 1'b0;
  assign rep        = 1'b0;
  assign stored_key = '0;
`endif

  assign rk_data = rep ? stored_key : ((idx == 4'd0) ? key_q : kg_key_o);
  assign rk_idx  = idx;
  assign kg_rcon = rcon;
  assign kg_key  = key_q;
  assign done    = done_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - bench for aes_key_sched_ctrl with a behavioural aes_key_gen round stage
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         nrst = 1'b1;
  logic         start = 1'b0;
  logic         start_ready;
  logic [127:0] key_i = '0;
  logic         abort = 1'b0;
  logic         kg_en, kg_gen_key, kg_next_rnd;
  logic [7:0]   kg_rcon;
  logic [127:0] kg_key;
  logic [127:0] kg_key_o;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         done;
`ifdef KEY_SCHED_CACHE_EN
  logic         replay = 1'b0;
  logic         cache_valid;
`endif

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk(clk), .nrst(nrst), .start(start), .start_ready(start_ready), .key_i(key_i),
    .abort(abort), .kg_en(kg_en), .kg_gen_key(kg_gen_key), .kg_next_rnd(kg_next_rnd),
    .kg_rcon(kg_rcon), .kg_key(kg_key), .kg_key_o(kg_key_o), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_data(rk_data), .rk_idx(rk_idx),
`ifdef KEY_SCHED_CACHE_EN
    .replay(replay), .cache_valid(cache_valid),
`endif
    .done(done)
  );

  logic [2047:0] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_tbl[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Stand-in for aes_key_gen: one registered round, reset by the shared reset.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) kg_key_o <= '0;
    else if (kg_en && kg_gen_key) kg_key_o <= next_key(kg_next_rnd ? kg_key_o : kg_key, kg_rcon);
  end

  logic [7:0] rq [$];
  logic       nq [$];
  always @(negedge clk) begin
    if (kg_en) begin
      rq.push_back(kg_rcon);
      nq.push_back(kg_next_rnd);
    end
  end

  typedef struct {
    logic [3:0]   idx;
    int           lat;
    logic [127:0] data;
    logic [7:0]   rcon;
    logic         nrnd;
  } vec_t;

  localparam logic [127:0] GOLD_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic [7:0] rcon_tab [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  vec_t vec [0:10];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_run(input logic [127:0] k, input logic rep);
    start = 1'b1;
    key_i = k;
`ifdef KEY_SCHED_CACHE_EN
    replay = rep;
`else
    if (rep) $display("replay requested without cache build");
`endif
    @(negedge clk);
    cyc   = 1;
    start = 1'b0;
`ifdef KEY_SCHED_CACHE_EN
    replay = 1'b0;
`endif
  endtask

  task automatic wait_valid(input string name);
    int b = 0;
    while (!rk_valid && b < 40) begin step(); b++; end
    chk(name, rk_valid, 1'b1);
  endtask

  task automatic wait_idx(input logic [3:0] target);
    int b = 0;
    while (!(rk_valid && rk_idx == target) && b < 40) begin step(); b++; end
    chk("reach_idx", rk_idx, target);
  endtask

  task automatic wait_done(input string name);
    int b = 0;
    while (!done && b < 40) begin step(); b++; end
    chk(name, done, 1'b1);
  endtask

  initial begin
    for (int r = 0; r <= 10; r++) begin
      vec[r].idx  = 4'(r);
      vec[r].lat  = 1 + 2 * r;
      vec[r].rcon = rcon_tab[r];
      vec[r].nrnd = (r > 1);
    end
    vec[0].data = GOLD_KEY;
    vec[1].data = 128'ha0fafe1788542cb123a339392a6c7605;
    for (int r = 2; r <= 9; r++) vec[r].data = next_key(vec[r-1].data, rcon_tab[r]);
    vec[10].data = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_start_ready", start_ready, 1'b1);
    chk("rst_rk_valid", rk_valid, 1'b0);
    chk("rst_kg_en", kg_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_kg_rcon", kg_rcon, 8'h01);
    chk("rst_rk_idx", rk_idx, 4'd0);
    nrst = 1'b0;
    step();

    // golden run, rk_ready tied high
    rq.delete(); nq.delete();
    start_run(GOLD_KEY, 1'b0);
    chk("gold_kg_key", kg_key, GOLD_KEY);
    for (int r = 0; r <= 10; r++) begin
      wait_valid("gold_valid");
      chk("gold_idx", rk_idx, vec[r].idx);
      chk("gold_data", rk_data, vec[r].data);
      chk("gold_latency", cyc, vec[r].lat);
      step();
    end
    chk("gold_done_t22", done, 1'b1);
    chk("gold_done_cyc", cyc, 22);
    chk("gold_start_ready", start_ready, 1'b1);
    step();
    chk("gold_done_pulse", done, 1'b0);
    chk("probe_kg_en_count", rq.size(), 10);
    for (int i = 0; i < 10 && i < rq.size(); i++) begin
      chk("probe_rcon", rq[i], vec[i+1].rcon);
      chk("probe_next_rnd", nq[i], vec[i+1].nrnd);
    end

`ifdef KEY_SCHED_CACHE_EN
    chk("cache_valid_set", cache_valid, 1'b1);
    rq.delete(); nq.delete();
    start_run(OTHER_KEY, 1'b1);
    for (int r = 0; r <= 10; r++) begin
      wait_valid("replay_valid");
      chk("replay_idx", rk_idx, vec[r].idx);
      chk("replay_data", rk_data, vec[r].data);
      chk("replay_latency", cyc, 1 + r);
      step();
    end
    chk("replay_done", done, 1'b1);
    chk("replay_kg_en_count", rq.size(), 0);
    step();
`endif

    // backpressure at idx3
    rq.delete(); nq.delete();
    start_run(GOLD_KEY, 1'b0);
    wait_idx(4'd3);
    rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", rk_valid, 1'b1);
      chk("bp_idx", rk_idx, 4'd3);
      chk("bp_data", rk_data, vec[3].data);
      chk("bp_kg_en", kg_en, 1'b0);
    end
    rk_ready = 1'b1;
    for (int r = 3; r <= 10; r++) begin
      wait_valid("bp_resume_valid");
      chk("bp_resume_idx", rk_idx, vec[r].idx);
      chk("bp_resume_data", rk_data, vec[r].data);
      step();
    end
    chk("bp_done", done, 1'b1);
    chk("bp_kg_en_count", rq.size(), 10);
    step();

    // abort at idx5 with start in the same cycle
    start_run(GOLD_KEY, 1'b0);
    wait_idx(4'd5);
    abort = 1'b1;
    start = 1'b1;
    key_i = OTHER_KEY;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_ready", start_ready, 1'b1);
    chk("abort_rk_valid", rk_valid, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_rk_idx", rk_idx, 4'd0);
    chk("abort_rcon", kg_rcon, 8'h01);
`ifdef KEY_SCHED_CACHE_EN
    chk("abort_cache_clr", cache_valid, 1'b0);
`endif
    step();
    chk("abort_no_done", done, 1'b0);
    chk("abort_still_idle", start_ready, 1'b1);
    start_run(GOLD_KEY, 1'b0);
    chk("restart_idx0", rk_idx, 4'd0);
    chk("restart_data0", rk_data, GOLD_KEY);
    step(); step();
    chk("restart_idx1", rk_idx, 4'd1);
    chk("restart_data1", rk_data, vec[1].data);
    wait_done("restart_done");
    step();

    // reset asserted mid-stream
    start_run(GOLD_KEY, 1'b0);
    wait_idx(4'd2);
    nrst = 1'b1;
    #1;
    chk("mrst_start_ready", start_ready, 1'b1);
    chk("mrst_rk_valid", rk_valid, 1'b0);
    chk("mrst_kg_en", kg_en, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_kg_rcon", kg_rcon, 8'h01);
    chk("mrst_rk_idx", rk_idx, 4'd0);
    step();
    nrst = 1'b0;
    step();
    start_run(OTHER_KEY, 1'b0);
    chk("post_rst_data0", rk_data, OTHER_KEY);
    step(); step();
    chk("post_rst_data1", rk_data, next_key(OTHER_KEY, 8'h01));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Sequencer that sits directly upstream of aes_key_gen.
- Accepts a 128-bit cipher key through a start handshake.
- Drives aes_key_gen's control and round-constant inputs one round at a time.
- Delivers round keys 0..NUM_ROUNDS in order to the cipher datapath over a valid/ready stream.
- Owns the rcon sequence, the round counter and backpressure, so aes_key_gen stays a pure one-round datapath.

Parameters:
- NUM_ROUNDS, 10, number of generated round keys (AES-128); round-key indices run 0..NUM_ROUNDS.
- RCON_INIT, 8'h01, rcon value used for round 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- nrst  in  1  reset, asynchronous, active-high; the codebase port name is kept, but the polarity is high.
- start  in  1  request a key expansion; accepted when start && start_ready.
- start_ready  out  1  high only in IDLE.
- key_i  in  128  cipher key; sampled on start acceptance.
- abort  in  1  synchronous cancel.
- kg_en  out  1  to aes_key_gen en.
- kg_gen_key  out  1  to aes_key_gen gen_key.
- kg_next_rnd  out  1  to aes_key_gen next_rnd.
- kg_rcon  out  8  to aes_key_gen r_con_ctrl.
- kg_key  out  128  to aes_key_gen key_i; holds the latched cipher key.
- kg_key_o  in  128  from aes_key_gen key_o.
- rk_valid  out  1  round key available.
- rk_ready  in  1  consumer accepts.
- rk_data  out  128  round key.
- rk_idx  out  4  round index 0..NUM_ROUNDS.
- done  out  1  one-cycle pulse after the last round key is accepted.

Behaviour:
- Reset values: all outputs 0, except start_ready=1; kg_rcon=RCON_INIT; FSM in IDLE; round counter 0.
- FSM states: IDLE, OUT, STEP.
- IDLE:
  - On start acceptance, latch key_i into kg_key, set rk_idx=0 and rcon=RCON_INIT, then go to OUT.
  - start while not in IDLE is ignored.
- OUT:
  - rk_valid=1.
  - rk_data = kg_key when rk_idx=0, else kg_key_o.
  - rk_data and rk_idx are held stable until rk_valid && rk_ready.
  - On that handshake: if rk_idx==NUM_ROUNDS, go to IDLE and pulse done next cycle; else go to STEP.
- STEP (exactly 1 cycle):
  - kg_en=1, kg_gen_key=1.
  - kg_next_rnd=0 for round 1, 1 otherwise.
  - kg_rcon = current rcon.
  - Increment rk_idx.
  - Advance rcon by xtime: {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
  - Go to OUT.
  - aes_key_gen registers the new key on this edge, so kg_key_o is valid in the following OUT cycle.
- kg_en is 0 in every state except STEP, so key_o stays frozen while the consumer stalls.
- kg_gen_key and kg_next_rnd are don't-care outside STEP and are driven 0.
- Latency with rk_ready tied high:
  - Start accepted at cycle T.
  - Key 0 valid at T+1.
  - Key r valid at T+1+2r.
  - done at T+22; start_ready returns high at T+22.
- Abort, in any non-IDLE state: next cycle is IDLE; rk_valid drops; no done pulse; rcon and counter are reset.
  - abort and rk handshake in the same cycle: abort wins (the transfer counts, but no further keys are issued).
  - abort in IDLE has no effect.
  - abort has priority over start.
- nrst asserted mid-operation: immediate return to reset values; aes_key_gen's own register is reset by the same signal.
- rcon sequence over rounds 1..10: 01 02 04 08 10 20 40 80 1B 36.

Optional Feature:
Macro KEY_SCHED_CACHE_EN.
- Enabled:
  - Adds an (NUM_ROUNDS+1)x128 round-key store, input port replay (1), and output port cache_valid (1).
  - Every OUT handshake writes rk_data at rk_idx.
  - cache_valid sets on done; it clears on reset, abort, or a new non-replay start.
  - start with replay=1 and cache_valid=1: key_i is ignored, kg_en stays 0, and stored keys 0..NUM_ROUNDS are emitted one per handshake.
  - Replay latency is 1 cycle per key (no STEP); done behaves as in the normal flow.
  - replay=1 with cache_valid=0 runs a normal expansion.
- Disabled: no store and no extra ports; behaviour is exactly as above.

Test Plan:
- Reset check: assert nrst mid-stream -> start_ready=1, rk_valid=0, kg_en=0, done=0, kg_rcon=01.
- FIPS-197 golden run with aes_key_gen plus an S-box model, rk_ready=1, key 2b7e151628aed2a6abf7158809cf4f3c:
  - idx1 = a0fafe1788542cb123a339392a6c7605.
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done at T+22.
- rcon/kg_en probe: kg_rcon sampled on each kg_en pulse = 01,02,04,08,10,20,40,80,1B,36; exactly 10 kg_en pulses; kg_next_rnd=0 only on the first.
- Backpressure: hold rk_ready=0 for 5 cycles at idx3 -> rk_data and rk_idx stable, kg_en=0 throughout, final keys match the golden run.
- Abort at idx5 with start asserted in the same cycle -> IDLE next cycle, no done, start_ready=1, then a new start succeeds from idx0.
- KEY_SCHED_CACHE_EN: after the golden run, start with replay=1 and a different key_i -> golden keys replayed, kg_en never asserted, idx10 at T+11.
